// File: rtl/lcd_bus_rx_if.sv
// 8080-style LCD write bus: data byte, WR strobe, D/C select.
interface lcd_bus_rx_if;
  logic [7:0] lcd_data;
  logic       lcd_wr;
  logic       lcd_dc;

  modport master (output lcd_data, lcd_wr, lcd_dc);
  modport slave  (input  lcd_data, lcd_wr, lcd_dc);
endinterface

// File: rtl/lcd_bus_rx.sv
// Receive side of an 8080 LCD write bus: decodes CASET/PASET/RAMWR and
// streams RGB565 pixels with their window coordinates.
module lcd_bus_rx #(
  parameter int H_RES = 320,
  parameter int V_RES = 96,
  parameter int COL_W = 10,
  parameter int ROW_W = 7
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  lcd_bus_rx_if.slave       bus,
  output logic              o_pix_valid,
  output logic [15:0]       o_pix_data,
  output logic [COL_W-1:0]  o_pix_x,
  output logic [ROW_W-1:0]  o_pix_y,
  output logic              o_frame_start,
  output logic              o_frame_end,
  output logic              o_unk_cmd,
  output logic              o_win_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CASET = 2'd1;
  localparam logic [1:0] S_PASET = 2'd2;
  localparam logic [1:0] S_RAMWR = 2'd3;

  logic [7:0]       r_data;
  logic             r_wr, r_wr_d, r_dc;
  logic [1:0]       r_state, r_pcnt;
  logic [23:0]      r_sh;
  logic [15:0]      r_sc, r_ec, r_sp, r_ep;
  logic [COL_W-1:0] r_x;
  logic [ROW_W-1:0] r_y;
  logic             r_phase, r_first;
  logic [7:0]       r_hi;
  logic             r_s1_vld, r_s1_fs, r_s1_fe;
  logic [15:0]      r_s1_data;
  logic [COL_W-1:0] r_s1_x;
  logic [ROW_W-1:0] r_s1_y;

  logic w_evt, w_win_ok, w_x_end, w_y_end, w_at_start;

  assign w_evt      = r_wr & ~r_wr_d;
  assign w_win_ok   = (r_sc <= r_ec) && (r_ec < 16'(H_RES)) &&
                      (r_sp <= r_ep) && (r_ep < 16'(V_RES));
  assign w_x_end    = (16'(r_x) == r_ec);
  assign w_y_end    = (16'(r_y) == r_ep);
  assign w_at_start = (16'(r_x) == r_sc) && (16'(r_y) == r_sp);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_data <= '0;
      r_wr   <= 1'b0;
      r_wr_d <= 1'b0;
      r_dc   <= 1'b0;
    end else begin
      r_data <= bus.lcd_data;
      r_wr   <= bus.lcd_wr;
      r_wr_d <= r_wr;
      r_dc   <= bus.lcd_dc;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state   <= S_IDLE;
      r_pcnt    <= '0;
      r_sh      <= '0;
      r_sc      <= '0;
      r_ec      <= 16'(H_RES - 1);
      r_sp      <= '0;
      r_ep      <= 16'(V_RES - 1);
      r_x       <= '0;
      r_y       <= '0;
      r_phase   <= 1'b0;
      r_first   <= 1'b0;
      r_hi      <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_fs   <= 1'b0;
      r_s1_fe   <= 1'b0;
      r_s1_data <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      o_unk_cmd <= 1'b0;
      o_win_err <= 1'b0;
    end else begin
      r_s1_vld  <= 1'b0;
      o_unk_cmd <= 1'b0;
      o_win_err <= 1'b0;
      if (w_evt && !r_dc) begin
        // any command restarts decoding and drops a half-received pixel
        r_phase <= 1'b0;
        r_pcnt  <= '0;
        case (r_data)
          8'h2A: r_state <= S_CASET;
          8'h2B: r_state <= S_PASET;
          8'h2C: begin
            if (w_win_ok) begin
              r_state <= S_RAMWR;
              r_x     <= r_sc[COL_W-1:0];
              r_y     <= r_sp[ROW_W-1:0];
              r_first <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              o_win_err <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            o_unk_cmd <= 1'b1;
          end
        endcase
      end else if (w_evt) begin
        case (r_state)
          S_CASET, S_PASET: begin
            r_sh   <= {r_sh[15:0], r_data};
            r_pcnt <= r_pcnt + 2'd1;
            if (r_pcnt == 2'd3) begin
              if (r_state == S_CASET) begin
                r_sc <= r_sh[23:8];
                r_ec <= {r_sh[7:0], r_data};
              end else begin
                r_sp <= r_sh[23:8];
                r_ep <= {r_sh[7:0], r_data};
              end
              r_state <= S_IDLE;
            end
          end
          S_RAMWR: begin
            if (!r_phase) begin
              r_hi    <= r_data;
              r_phase <= 1'b1;
            end else begin
              r_phase   <= 1'b0;
              r_s1_vld  <= 1'b1;
              r_s1_data <= {r_hi, r_data};
              r_s1_x    <= r_x;
              r_s1_y    <= r_y;
              r_s1_fs   <= r_first && w_at_start;
              r_s1_fe   <= w_x_end && w_y_end;
              // wrapping past the window end re-arms frame_start
              r_first   <= w_x_end && w_y_end;
              if (w_x_end) begin
                r_x <= r_sc[COL_W-1:0];
                r_y <= w_y_end ? r_sp[ROW_W-1:0] : r_y + ROW_W'(1);
              end else begin
                r_x <= r_x + COL_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_pix_valid   <= 1'b0;
      o_pix_data    <= '0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
    end else begin
      o_pix_valid   <= r_s1_vld;
      o_frame_start <= r_s1_vld & r_s1_fs;
      o_frame_end   <= r_s1_vld & r_s1_fe;
      if (r_s1_vld) begin
        o_pix_data <= r_s1_data;
        o_pix_x    <= r_s1_x;
        o_pix_y    <= r_s1_y;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: drives bus sequences, collects pixels, checks.
module tb_lcd_bus_rx;
  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        pix_valid, frame_start, frame_end, unk_cmd, win_err;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [6:0]  pix_y;

  int n_chk = 0, n_err = 0;
  int n_unk = 0, n_werr = 0, n_wide = 0;
  logic prev_v = 1'b0;
  logic [63:0] pq[$];

  lcd_bus_rx_if bus();

  lcd_bus_rx #(.H_RES(320), .V_RES(96), .COL_W(10), .ROW_W(7)) dut (
    .i_clk(clk), .i_res_n(res_n), .bus(bus),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_x(pix_x),
    .o_pix_y(pix_y), .o_frame_start(frame_start), .o_frame_end(frame_end),
    .o_unk_cmd(unk_cmd), .o_win_err(win_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic fs, input logic fe,
                                     input int x, input int y, input logic [15:0] d);
    return {29'b0, fs, fe, 7'(y), 10'(x), d};
  endfunction

  function automatic logic [15:0] pdat(input int i);
    return 16'(i * 37 + 5);
  endfunction

  always @(negedge clk) begin
    if (pix_valid) pq.push_back(pk(frame_start, frame_end, int'(pix_x), int'(pix_y), pix_data));
    if (pix_valid && prev_v) n_wide++;
    prev_v = pix_valid;
    if (unk_cmd) n_unk++;
    if (win_err) n_werr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic dc, input logic [7:0] b, input int hold = 1);
    @(negedge clk);
    bus.lcd_data = b; bus.lcd_dc = dc; bus.lcd_wr = 1'b1;
    repeat (hold) @(negedge clk);
    bus.lcd_wr = 1'b0;
  endtask

  task automatic send_pix(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = pdat(i);
      send(1'b1, d[15:8]);
      send(1'b1, d[7:0]);
    end
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0; bus.lcd_wr = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    pq.delete();
  endtask

  task automatic cmd4(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e, input logic [7:0] f);
    send(1'b0, c); send(1'b1, a); send(1'b1, b); send(1'b1, e); send(1'b1, f);
  endtask

  task automatic chk_stream(input string tag, input int sc, input int w,
                            input int sp, input int h, input int n);
    int bad = 0;
    int per = w * h;
    chk({tag, "_cnt"}, 64'(pq.size()), 64'(n));
    for (int i = 0; i < n && i < pq.size(); i++)
      if (pq[i] !== pk(i % per == 0, i % per == per - 1, sc + i % w,
                       sp + (i / w) % h, pdat(i))) bad++;
    chk({tag, "_px"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int u0, w0;
    bus.lcd_data = '0; bus.lcd_dc = 1'b0; bus.lcd_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_end, unk_cmd, win_err}, '0);
    res_n = 1'b1;

    // RAMWR at reset window; WR held high on the high byte; latency check
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12, 4);
    @(negedge clk);
    bus.lcd_data = 8'h34; bus.lcd_dc = 1'b1; bus.lcd_wr = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("lat_c1", pix_valid, 1'b0);
    bus.lcd_wr = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lat_c2", pix_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("lat_c3", {pix_valid, frame_start, frame_end, pix_data, pix_x, pix_y},
        {1'b1, 1'b1, 1'b0, 16'h1234, 10'd0, 7'd0});
    @(negedge clk);
    chk("pulse_w", {pix_valid, pix_data}, {1'b0, 16'h1234});
    drain();
    chk("held_wr_cnt", 64'(pq.size()), 64'd1);

    // partial CASET leaves window; command drops pending high byte
    do_reset();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05);
    send(1'b0, 8'h2C); send(1'b1, 8'hAB);
    send(1'b0, 8'h2C); send(1'b1, 8'h00); send(1'b1, 8'h01);
    drain();
    chk("abort_cnt", 64'(pq.size()), 64'd1);
    chk("abort_px", pq[0], pk(1'b1, 1'b0, 0, 0, 16'h0001));

    // unknown command, then invalid window
    pq.delete(); u0 = n_unk; w0 = n_werr;
    send(1'b0, 8'h29); send(1'b1, 8'h11); send(1'b1, 8'h22);
    drain();
    chk("unk_pulse", 64'(n_unk - u0), 64'd1);
    chk("unk_nopix", 64'(pq.size()), 64'd0);
    cmd4(8'h2A, 8'h00, 8'h00, 8'h01, 8'h40);
    send(1'b0, 8'h2C); send(1'b1, 8'h11); send(1'b1, 8'h22);
    drain();
    chk("werr_pulse", 64'(n_werr - w0), 64'd1);
    chk("werr_nopix", 64'(pq.size()), 64'd0);
    chk("werr_nounk", 64'(n_unk - u0), 64'd1);

    // 1x1 window: every pixel is both start and end
    cmd4(8'h2A, 8'h00, 8'h03, 8'h00, 8'h03);
    cmd4(8'h2B, 8'h00, 8'h02, 8'h00, 8'h02);
    send(1'b0, 8'h2C); send_pix(2); drain();
    chk_stream("w1x1", 3, 1, 2, 1, 2);

    // 2x2 window with wrap
    pq.delete();
    cmd4(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B);
    cmd4(8'h2B, 8'h00, 8'h05, 8'h00, 8'h06);
    send(1'b0, 8'h2C); send_pix(5); drain();
    chk_stream("w2x2", 10, 2, 5, 2, 5);

    // full panel window: row advance at pixel 320
    pq.delete();
    cmd4(8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F);
    cmd4(8'h2B, 8'h00, 8'h00, 8'h00, 8'h5F);
    send(1'b0, 8'h2C); send_pix(321); drain();
    chk_stream("full", 0, 320, 0, 96, 321);
    chk("px320_yx", pq[320][32:16], {7'd1, 10'd0});

    // bottom two rows: frame end at (319,95), wrap back with frame start
    pq.delete();
    cmd4(8'h2B, 8'h00, 8'h5E, 8'h00, 8'h5F);
    send(1'b0, 8'h2C); send_pix(642); drain();
    chk_stream("rows", 0, 320, 94, 2, 642);
    chk("last_fe", pq[639][34:16], {1'b0, 1'b1, 7'd95, 10'd319});
    chk("wrap_fs", pq[640][34:16], {1'b1, 1'b0, 7'd94, 10'd0});

    // reset mid-RAMWR with a pending high byte
    do_reset();
    send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34); send(1'b1, 8'h55);
    drain();
    chk("pre_rst", {64'(pq.size()), pix_data}, {64'd1, 16'h1234});
    #3 res_n = 1'b0;
    #1 chk("mid_rst", {pix_valid, pix_data, pix_x, pix_y, frame_start, frame_end, unk_cmd, win_err}, '0);
    @(negedge clk); res_n = 1'b1;
    send(1'b1, 8'h66); send(1'b1, 8'h77); drain();
    chk("post_rst", 64'(pq.size()), 64'd1);
    chk("valid_width", 64'(n_wide), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
